// File: rtl/uart_boot_loader_if.sv
// Byte-stream and instruction-memory write bundle for the UART boot loader.
//   rx_data   : received byte from uart_rx
//   rx_en     : byte valid (level, held until acknowledged)
//   rx_comp   : byte consumed, one-cycle pulse back to uart_rx
//   mem_we    : imem write strobe, one-cycle pulse
//   mem_addr  : imem word address
//   mem_wdata : imem write data
// Modport master is the loader side; slave is the uart_rx / imem side.
interface uart_boot_loader_if #(
    parameter int unsigned ADDR_WIDTH = 14
) ();
    logic [7:0]            rx_data;
    logic                  rx_en;
    logic                  rx_comp;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;

    modport master (
        input  rx_data,
        input  rx_en,
        output rx_comp,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output rx_data,
        output rx_en,
        input  rx_comp,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/uart_boot_loader.sv
// Power-up boot loader. Consumes bytes from uart_rx, parses a framed image
// (sync byte, 32-bit LE word count, LE data words) and writes the words into
// instruction memory, keeping the core in reset until the load completes.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : uart_boot_loader_if.master (rx handshake + imem write port)
//   cpu_rst_n  : core reset, released only after a complete load
//   busy       : high while a frame is being received or written
//   err        : sticky status, 00 ok / 01 timeout / 10 length overflow
module uart_boot_loader #(
    parameter int unsigned ADDR_WIDTH     = 14,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    uart_boot_loader_if.master        bus,
    output logic                      cpu_rst_n,
    output logic                      busy,
    output logic [1:0]                err
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LEN   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    // One bit wider than the count so 2**32 never truncates for large ADDR_WIDTH.
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_WIDTH;

    logic [2:0]            state_r;
    logic [2:0]            state_nxt_s;
    logic                  rx_comp_r;
    logic                  mem_we_r;
    logic                  cpu_rst_n_r;
    logic                  busy_r;
    logic [1:0]            err_r;
    logic [ADDR_WIDTH-1:0] mem_addr_r;
    logic [31:0]           mem_wdata_r;
    logic [23:0]           len_r;
    logic [31:0]           words_left_r;
    logic [31:0]           to_cnt_r;
    logic [1:0]            byte_cnt_r;

    logic                  accept_s;
    logic                  in_frame_s;
    logic                  last_byte_s;
    logic                  sync_s;
    logic                  timeout_s;
    logic                  len_ovf_s;
    logic [31:0]           len_full_s;

    // The 4th length byte is combined directly, so only three bytes are stored.
    assign len_full_s  = {bus.rx_data, len_r};
    assign len_ovf_s   = ({1'b0, len_full_s} > CAPACITY);
    assign in_frame_s  = (state_r == ST_LEN) || (state_r == ST_DATA);
    assign last_byte_s = (byte_cnt_r == 2'd3);
    assign sync_s      = (state_r == ST_IDLE) && accept_s && (bus.rx_data == SYNC_BYTE);

    // A byte is taken only when not already acknowledging one and the FSM can consume it.
    always_comb begin
        accept_s = 1'b0;
        if (bus.rx_en && !rx_comp_r && ((state_r == ST_IDLE) || in_frame_s)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // An accepted byte in the same cycle takes priority over expiry.
    always_comb begin
        timeout_s = 1'b0;
        if (in_frame_s && !accept_s && (to_cnt_r == (TIMEOUT_CYCLES - 32'd1))) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Next-state logic of the frame parser.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sync_s) begin
                    state_nxt_s = ST_LEN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (accept_s && last_byte_s) begin
                    if (len_full_s == 32'd0) begin
                        state_nxt_s = ST_DONE;
                    end else if (len_ovf_s) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_LEN;
                end
            end
            ST_DATA: begin
                if (timeout_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (accept_s && last_byte_s) begin
                    state_nxt_s = ST_WRITE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (words_left_r == 32'd1) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_DONE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, handshake and status registers; busy/cpu_rst_n follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rx_comp_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            cpu_rst_n_r <= 1'b0;
            busy_r      <= 1'b0;
            err_r       <= ERR_OK;
        end else begin
            state_r     <= state_nxt_s;
            rx_comp_r   <= accept_s;
            mem_we_r    <= (state_r == ST_DATA) && accept_s && last_byte_s;
            cpu_rst_n_r <= (state_nxt_s == ST_DONE);
            busy_r      <= (state_nxt_s == ST_LEN) || (state_nxt_s == ST_DATA) ||
                           (state_nxt_s == ST_WRITE);
            if (sync_s) begin
                err_r <= ERR_OK;
            end else if ((state_r == ST_LEN) && accept_s && last_byte_s && len_ovf_s) begin
                err_r <= ERR_OVERFLOW;
            end else if (timeout_s) begin
                err_r <= ERR_TIMEOUT;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Byte position within the current 4-byte field; wraps naturally between fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_r <= 2'd0;
        end else if (sync_s || timeout_s) begin
            byte_cnt_r <= 2'd0;
        end else if (in_frame_s && accept_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
        end else begin
            byte_cnt_r <= byte_cnt_r;
        end
    end

    // Collects the low three length bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r <= 24'd0;
        end else if (sync_s) begin
            len_r <= 24'd0;
        end else if ((state_r == ST_LEN) && accept_s) begin
            case (byte_cnt_r)
                2'd0:    len_r[7:0]   <= bus.rx_data;
                2'd1:    len_r[15:8]  <= bus.rx_data;
                2'd2:    len_r[23:16] <= bus.rx_data;
                default: len_r        <= len_r;
            endcase
        end else begin
            len_r <= len_r;
        end
    end

    // Remaining word count and write address; the address stops on the final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_left_r <= 32'd0;
            mem_addr_r   <= '0;
        end else if (sync_s) begin
            words_left_r <= 32'd0;
            mem_addr_r   <= '0;
        end else if ((state_r == ST_LEN) && accept_s && last_byte_s) begin
            words_left_r <= len_full_s;
            mem_addr_r   <= mem_addr_r;
        end else if (state_r == ST_WRITE) begin
            words_left_r <= words_left_r - 32'd1;
            if (words_left_r != 32'd1) begin
                mem_addr_r <= mem_addr_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                mem_addr_r <= mem_addr_r;
            end
        end else begin
            words_left_r <= words_left_r;
            mem_addr_r   <= mem_addr_r;
        end
    end

    // Assembles the data word little-endian, one byte lane per accepted byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wdata_r <= 32'd0;
        end else if ((state_r == ST_DATA) && accept_s) begin
            mem_wdata_r[{byte_cnt_r, 3'b000} +: 8] <= bus.rx_data;
        end else begin
            mem_wdata_r <= mem_wdata_r;
        end
    end

    // Inter-byte idle counter; only runs while a frame is being received.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r <= 32'd0;
        end else if (in_frame_s) begin
            if (accept_s || timeout_s) begin
                to_cnt_r <= 32'd0;
            end else begin
                to_cnt_r <= to_cnt_r + 32'd1;
            end
        end else if (state_r == ST_WRITE) begin
            to_cnt_r <= to_cnt_r;
        end else begin
            to_cnt_r <= 32'd0;
        end
    end

    assign bus.rx_comp   = rx_comp_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign cpu_rst_n     = cpu_rst_n_r;
    assign busy          = busy_r;
    assign err           = err_r;
endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed frames plus randomized
// images compared against a frame-parsing reference model.
module tb_uart_boot_loader;
    localparam int unsigned AW   = 4;
    localparam int unsigned CAP  = 16;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_rst_n;
    logic       busy;
    logic [1:0] err;

    uart_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    uart_boot_loader #(
        .ADDR_WIDTH    (AW),
        .SYNC_BYTE     (SYNC),
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .cpu_rst_n(cpu_rst_n),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int comp_cnt = 0;

    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];
    logic [7:0]    stim_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [31:0]   exp_data_q[$];
    logic [1:0]    exp_err;
    bit            exp_done;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Capture writes and count acknowledge pulses away from the active edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.rx_comp === 1'b1) comp_cnt++;
        if (rst_n === 1'b1 && bus.mem_we === 1'b1) begin
            wr_addr_q.push_back(bus.mem_addr);
            wr_data_q.push_back(bus.mem_wdata);
            check("we_latency", {63'd0, bus.rx_comp}, 64'd1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_comp"},   {63'd0, bus.rx_comp}, 64'd0);
        check({tag, "_mem_we"},    {63'd0, bus.mem_we}, 64'd0);
        check({tag, "_mem_addr"},  {60'd0, bus.mem_addr}, 64'd0);
        check({tag, "_mem_wdata"}, {32'd0, bus.mem_wdata}, 64'd0);
        check({tag, "_cpu_rst_n"}, {63'd0, cpu_rst_n}, 64'd0);
        check({tag, "_busy"},      {63'd0, busy}, 64'd0);
        check({tag, "_err"},       {62'd0, err}, 64'd0);
    endtask

    task automatic do_reset();
        bus.rx_en   = 1'b0;
        bus.rx_data = 8'h00;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr_addr_q.delete();
        wr_data_q.delete();
        stim_q.delete();
        comp_cnt = 0;
    endtask

    // Behaves like a registered uart_rx: rx_en stays high through the acknowledge cycle.
    task automatic send_byte(input logic [7:0] b);
        bit seen = 1'b0;
        bus.rx_data = b;
        bus.rx_en   = 1'b1;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.rx_comp === 1'b1) seen = 1'b1;
        end
        check("byte_accepted", {63'd0, seen}, 64'd1);
        @(posedge clk);
        #1;
        bus.rx_en = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic send_from(input int from);
        for (int i = from; i < stim_q.size(); i++) send_byte(stim_q[i]);
    endtask

    task automatic push_len(input logic [31:0] n);
        stim_q.push_back(SYNC);
        stim_q.push_back(n[7:0]);
        stim_q.push_back(n[15:8]);
        stim_q.push_back(n[23:16]);
        stim_q.push_back(n[31:24]);
    endtask

    task automatic push_word(input logic [31:0] w);
        stim_q.push_back(w[7:0]);
        stim_q.push_back(w[15:8]);
        stim_q.push_back(w[23:16]);
        stim_q.push_back(w[31:24]);
    endtask

    // Reference: scan the byte stream for frames and list the words they deliver.
    task automatic model_stream();
        int i = 0;
        longint unsigned n;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_err  = 2'b00;
        exp_done = 1'b0;
        while (i < stim_q.size() && !exp_done) begin
            if (stim_q[i] != SYNC) begin
                i++;
                continue;
            end
            exp_err = 2'b00;
            i++;
            if (i + 4 > stim_q.size()) break;
            n = {32'd0, stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]};
            i += 4;
            if (n > CAP) begin
                exp_err = 2'b10;
                continue;
            end
            if (i + 4 * int'(n) > stim_q.size()) break;
            for (int w = 0; w < int'(n); w++) begin
                exp_addr_q.push_back(w[AW-1:0]);
                exp_data_q.push_back({stim_q[i+3], stim_q[i+2], stim_q[i+1], stim_q[i]});
                i += 4;
            end
            exp_done = 1'b1;
        end
    endtask

    task automatic compare_results(input string tag);
        int n;
        model_stream();
        check({tag, "_nwrites"}, wr_data_q.size(), exp_data_q.size());
        n = (wr_data_q.size() < exp_data_q.size()) ? wr_data_q.size() : exp_data_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), {60'd0, wr_addr_q[i]}, {60'd0, exp_addr_q[i]});
            check($sformatf("%s_data%0d", tag, i), {32'd0, wr_data_q[i]}, {32'd0, exp_data_q[i]});
        end
        check({tag, "_cpu_rst_n"}, {63'd0, cpu_rst_n}, {63'd0, exp_done});
        check({tag, "_busy"},      {63'd0, busy}, 64'd0);
        check({tag, "_err"},       {62'd0, err}, {62'd0, exp_err});
    endtask

    initial begin
        int n_words;
        int split;
        bus.rx_en   = 1'b0;
        bus.rx_data = 8'h00;
        rst_n       = 1'b0;
        #3;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Handshake: one byte, rx_en held through the acknowledge cycle.
        comp_cnt = 0;
        send_byte(8'h3C);
        repeat (4) @(posedge clk);
        #1;
        check("hs_pulses", comp_cnt, 64'd1);
        check("hs_idle_busy", {63'd0, busy}, 64'd0);

        // Load with leading junk bytes.
        do_reset();
        stim_q = '{8'h00, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h00,
                   8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
        send_from(0);
        repeat (3) @(posedge clk);
        #1;
        compare_results("load");
        if (wr_data_q.size() == 2) begin
            check("load_w0", {32'd0, wr_data_q[0]}, 64'hDEADBEEF);
            check("load_w1", {32'd0, wr_data_q[1]}, 64'h12345678);
        end
        check("load_pulses", comp_cnt, 64'd15);

        // Zero length, then rx_en ignored in DONE.
        do_reset();
        push_len(32'd0);
        send_from(0);
        repeat (3) @(posedge clk);
        #1;
        compare_results("zero");
        comp_cnt = 0;
        bus.rx_data = 8'h55;
        bus.rx_en   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.rx_en = 1'b0;
        check("done_ignores_rx", comp_cnt, 64'd0);
        check("done_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd1);

        // Overflow (17 > 16) followed by a full-capacity load.
        do_reset();
        push_len(32'd17);
        send_from(0);
        repeat (3) @(posedge clk);
        #1;
        compare_results("ovf");
        split = stim_q.size();
        push_len(32'd16);
        for (int i = 0; i < 16; i++) push_word($urandom);
        send_from(split);
        repeat (3) @(posedge clk);
        #1;
        compare_results("ovf_reload");

        // Timeout in DATA after a partial word.
        do_reset();
        stim_q = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
        send_from(0);
        repeat (90) @(posedge clk);
        #1;
        check("to_early_err", {62'd0, err}, 64'd0);
        check("to_early_busy", {63'd0, busy}, 64'd1);
        repeat (20) @(posedge clk);
        #1;
        check("to_err", {62'd0, err}, 64'd1);
        check("to_busy", {63'd0, busy}, 64'd0);
        check("to_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd0);
        check("to_nwrites", wr_data_q.size(), 64'd0);

        // Reset mid-DATA: first word written, second partial word dropped.
        do_reset();
        push_len(32'd3);
        push_word(32'hCAFE0001);
        stim_q.push_back(8'h77);
        stim_q.push_back(8'h66);
        send_from(0);
        check("mid_busy", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("mid_rst");
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mid_nwrites", wr_data_q.size(), 64'd1);
        check("mid_cpu_rst_n", {63'd0, cpu_rst_n}, 64'd0);

        // Randomized images with optional junk and overflow prefixes.
        for (int it = 0; it < 10; it++) begin
            do_reset();
            repeat ($urandom_range(0, 3)) begin
                logic [7:0] j;
                j = 8'($urandom_range(0, 255));
                if (j == SYNC) j = 8'h00;
                stim_q.push_back(j);
            end
            if ($urandom_range(0, 3) == 0) push_len(32'($urandom_range(17, 70000)));
            n_words = (it == 0) ? 16 : $urandom_range(0, 16);
            push_len(32'(n_words));
            for (int w = 0; w < n_words; w++) push_word($urandom);
            send_from(0);
            repeat (3) @(posedge clk);
            #1;
            compare_results($sformatf("rand%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
